// File: rtl/data_mem_map_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_map_if
//  Description : Load/store bus between the core datapath and the data-memory
//                and I/O decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_map_if;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] A;
    logic [31:0] WriteData;
    logic [3:0]  ByteEn;
    logic [31:0] ReadData;

    modport master (
        output MemWrite,
        output MemRead,
        output A,
        output WriteData,
        output ByteEn,
        input  ReadData
    );

    modport slave (
        input  MemWrite,
        input  MemRead,
        input  A,
        input  WriteData,
        input  ByteEn,
        output ReadData
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_map.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_map
//  Description : Data-memory / I/O decoder: byte-enabled data RAM, downward
//                stack window, UART RX FIFO with status, and sticky capture
//                of unmapped accesses. Loads are combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_map #(
    parameter logic [31:0] DATA_BASE   = 32'h0000_1000,
    parameter int          DATA_WORDS  = 2048,
    parameter logic [31:0] STACK_TOP   = 32'hFFFF_FFFC,
    parameter int          STACK_WORDS = 16,
    parameter logic [31:0] UART_BASE   = 32'h0000_4000,
    parameter int          FIFO_DEPTH  = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,          // asynchronous, active-low
    data_mem_map_if.slave    bus,
    input  wire logic        uart_valid,
    input  wire logic [7:0]  uart_byte,
    output logic             rx_nonempty,
    output logic             bus_fault,
    output logic [31:0]      fault_addr
);

    localparam int DIDX_W = $clog2(DATA_WORDS);
    localparam int SIDX_W = $clog2(STACK_WORDS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [31:0]      c_data_words  = 32'(DATA_WORDS);
    localparam logic [31:0]      c_stack_words = 32'(STACK_WORDS);
    localparam logic [PTR_W:0]   c_fifo_full   = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [31:0]      c_uart_data   = UART_BASE;
    localparam logic [31:0]      c_uart_stat   = UART_BASE + 32'd4;
    localparam logic [31:0]      c_uart_fault  = UART_BASE + 32'd8;

    // Storage
    logic [31:0]      r_data_mem  [DATA_WORDS];
    logic [31:0]      r_stack_mem [STACK_WORDS];
    logic [7:0]       r_fifo      [FIFO_DEPTH];

    // FIFO and fault state
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_overflow;
    logic             r_bus_fault;
    logic [31:0]      r_fault_addr;

    // Decode
    logic [31:0]       w_addr;
    logic [31:0]       w_data_off;
    logic [31:0]       w_stack_off;
    logic              w_data_hit;
    logic              w_stack_hit;
    logic              w_io_data;
    logic              w_io_stat;
    logic              w_io_fault;
    logic              w_mapped;
    logic [DIDX_W-1:0] w_data_idx;
    logic [SIDX_W-1:0] w_stack_idx;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_ovf_set;
    logic w_ovf_clr;
    logic w_unmapped;
    logic w_fault_clr;
    logic w_unused_ok;

    // Word-align the address; the low two bits never select anything
    assign w_addr      = {bus.A[31:2], 2'b00};
    assign w_data_off  = w_addr - DATA_BASE;
    assign w_stack_off = STACK_TOP - w_addr;
    assign w_data_hit  = (w_addr >= DATA_BASE) &&
                         ({2'b00, w_data_off[31:2]} < c_data_words);
    assign w_stack_hit = (w_addr <= STACK_TOP) &&
                         ({2'b00, w_stack_off[31:2]} < c_stack_words);
    assign w_data_idx  = w_data_off[DIDX_W+1:2];
    assign w_stack_idx = w_stack_off[SIDX_W+1:2];
    assign w_io_data   = (w_addr == c_uart_data);
    assign w_io_stat   = (w_addr == c_uart_stat);
    assign w_io_fault  = (w_addr == c_uart_fault);
    assign w_mapped    = w_data_hit | w_stack_hit | w_io_data | w_io_stat | w_io_fault;
    assign w_unused_ok = &{1'b0, w_data_off[1:0], w_stack_off[1:0]};

    // FIFO control: a pop frees the slot a same-cycle push needs when full
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_fifo_full);
    assign w_pop       = w_io_data & bus.MemRead & ~w_empty;
    assign w_push      = uart_valid & (~w_full | w_pop);
    assign w_ovf_set   = uart_valid & w_full & ~w_pop;
    assign w_ovf_clr   = bus.MemWrite & w_io_stat & bus.WriteData[31];
    assign w_unmapped  = ~w_mapped & (bus.MemRead | bus.MemWrite);
    assign w_fault_clr = bus.MemWrite & w_io_fault;

    assign rx_nonempty = ~w_empty;
    assign bus_fault   = r_bus_fault;
    assign fault_addr  = r_fault_addr;

    // Combinational load mux; unmapped addresses read as all-ones
    always_comb begin
        bus.ReadData = 32'hFFFF_FFFF;
        if (w_data_hit) begin
            bus.ReadData = r_data_mem[w_data_idx];
        end else if (w_stack_hit) begin
            bus.ReadData = r_stack_mem[w_stack_idx];
        end else if (w_io_data) begin
            bus.ReadData = {w_empty, 23'b0, (w_empty ? 8'h00 : r_fifo[r_rd_ptr])};
        end else if (w_io_stat) begin
            bus.ReadData = {r_overflow, 15'b0, 16'(r_count)};
        end else if (w_io_fault) begin
            bus.ReadData = {r_bus_fault, 31'b0};
        end
    end

    // Byte-lane stores to data and stack; a store under reset is discarded
    always_ff @(posedge clk) begin
        if (rst && bus.MemWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.ByteEn[b]) begin
                    if (w_data_hit)
                        r_data_mem[w_data_idx][8*b +: 8] <= bus.WriteData[8*b +: 8];
                    else if (w_stack_hit)
                        r_stack_mem[w_stack_idx][8*b +: 8] <= bus.WriteData[8*b +: 8];
                end
            end
        end
    end

    // FIFO storage write at the tail
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_fifo[r_wr_ptr] <= uart_byte;
        end
    end

    // FIFO pointers/count, overflow flag and sticky fault capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_bus_fault  <= 1'b0;
            r_fault_addr <= 32'h0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_ovf_set)      r_overflow <= 1'b1;
            else if (w_ovf_clr) r_overflow <= 1'b0;

            if (w_fault_clr) begin
                r_bus_fault  <= 1'b0;
                r_fault_addr <= 32'h0;
            end else if (w_unmapped) begin
                r_bus_fault <= 1'b1;
                if (!r_bus_fault) r_fault_addr <= bus.A;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_map.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_map
//  Description : Directed self-checking bench for data_mem_map.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_map;

    localparam logic [31:0] c_stat  = 32'h0000_4004;
    localparam logic [31:0] c_rxdat = 32'h0000_4000;
    localparam logic [31:0] c_fault = 32'h0000_4008;

    logic        clk;
    logic        rst;
    logic        uart_valid;
    logic [7:0]  uart_byte;
    logic        rx_nonempty;
    logic        bus_fault;
    logic [31:0] fault_addr;

    int checks;
    int errors;

    data_mem_map_if bus ();

    data_mem_map dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .uart_valid  (uart_valid),
        .uart_byte   (uart_byte),
        .rx_nonempty (rx_nonempty),
        .bus_fault   (bus_fault),
        .fault_addr  (fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus drivers ----------------
    task automatic idle();
        bus.MemWrite  = 1'b0;
        bus.MemRead   = 1'b0;
        bus.ByteEn    = 4'h0;
        bus.WriteData = 32'h0;
        uart_valid    = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        bus.A = a; bus.WriteData = d; bus.ByteEn = be; bus.MemWrite = 1'b1;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.A = a; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
        #1 d = bus.ReadData;
    endtask

    task automatic load_pop(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.A = a; bus.MemRead = 1'b1;
        #1 d = bus.ReadData;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        uart_valid = 1'b1; uart_byte = b;
        @(posedge clk); #1;
        uart_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] d;
        checks++;
        if (rx_nonempty !== 1'b0 || bus_fault !== 1'b0 || fault_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got nonempty=%b fault=%b addr=%h, want 0 0 0",
                     rx_nonempty, bus_fault, fault_addr);
        end
        @(negedge clk) rst = 1'b1;
        peek(c_stat, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_stat: got %h want 00000000", d); end
        peek(c_rxdat, d);
        checks++;
        if (d !== 32'h8000_0000) begin errors++; $display("FAIL reset_rxdata: got %h want 80000000", d); end
    endtask

    task automatic test_data_region();
        logic [31:0] d;
        store(32'h1000, 32'hDEAD_BEEF, 4'hF);
        store(32'h1000, 32'h0000_5500, 4'b0010);
        peek(32'h1000, d);
        checks++;
        if (d !== 32'hDEAD_55EF) begin errors++; $display("FAIL data_byteen: got %h want DEAD55EF", d); end
        store(32'h1000, 32'h1234_5678, 4'h0);
        peek(32'h1002, d);
        checks++;
        if (d !== 32'hDEAD_55EF) begin errors++; $display("FAIL data_be0_noop: got %h want DEAD55EF", d); end
        store(32'h2FFC, 32'h0000_0001, 4'hF);
        peek(32'h2FFC, d);
        checks++;
        if (d !== 32'h0000_0001) begin errors++; $display("FAIL data_last_word: got %h want 00000001", d); end
        peek(32'h3000, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL data_above_end: got %h want FFFFFFFF", d); end
        peek(32'h0FFC, d);
        checks++;
        if (d !== 32'hFFFF_FFFF || bus_fault !== 1'b0) begin
            errors++;
            $display("FAIL data_below_base_nostrobe: got %h fault=%b want FFFFFFFF fault=0", d, bus_fault);
        end
    endtask

    task automatic test_stack();
        logic [31:0] d;
        store(32'hFFFF_FFFC, 32'h0000_CAFE, 4'hF);
        store(32'hFFFF_FFC0, 32'h0000_BEEF, 4'hF);
        peek(32'hFFFF_FFFC, d);
        checks++;
        if (d !== 32'h0000_CAFE) begin errors++; $display("FAIL stack_top: got %h want 0000CAFE", d); end
        peek(32'hFFFF_FFC0, d);
        checks++;
        if (d !== 32'h0000_BEEF) begin errors++; $display("FAIL stack_idx15: got %h want 0000BEEF", d); end
        store(32'hFFFF_FFBC, 32'h1111_1111, 4'hF);
        checks++;
        if (bus_fault !== 1'b1 || fault_addr !== 32'hFFFF_FFBC) begin
            errors++;
            $display("FAIL stack_overrun_fault: got fault=%b addr=%h want 1 FFFFFFBC", bus_fault, fault_addr);
        end
        peek(32'hFFFF_FFBC, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL stack_overrun_read: got %h want FFFFFFFF", d); end
        peek(c_fault, d);
        checks++;
        if (d !== 32'h8000_0000) begin errors++; $display("FAIL fault_reg_set: got %h want 80000000", d); end
        store(c_fault, 32'h0, 4'h0);
        peek(c_fault, d);
        checks++;
        if (d !== 32'h0 || bus_fault !== 1'b0 || fault_addr !== 32'h0) begin
            errors++;
            $display("FAIL fault_clear: got reg=%h fault=%b addr=%h want 0 0 0", d, bus_fault, fault_addr);
        end
    endtask

    task automatic test_fifo_basic();
        logic [31:0] d;
        logic [7:0]  exp_b [3];
        exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
        push(8'h41);
        checks++;
        if (rx_nonempty !== 1'b1) begin errors++; $display("FAIL rx_nonempty_rise: got %b want 1", rx_nonempty); end
        push(8'h42);
        push(8'h43);
        peek(c_stat, d);
        checks++;
        if (d !== 32'h0000_0003) begin errors++; $display("FAIL stat_three: got %h want 00000003", d); end
        store(c_rxdat, 32'hFFFF_FFFF, 4'hF);
        peek(c_stat, d);
        checks++;
        if (d !== 32'h0000_0003) begin errors++; $display("FAIL rxdata_store_ignored: got %h want 00000003", d); end
        for (int i = 0; i < 3; i++) begin
            load_pop(c_rxdat, d);
            checks++;
            if (d !== {24'h0, exp_b[i]}) begin
                errors++;
                $display("FAIL pop_%0d: got %h want %h", i, d, {24'h0, exp_b[i]});
            end
        end
        load_pop(c_rxdat, d);
        checks++;
        if (d !== 32'h8000_0000) begin errors++; $display("FAIL pop_empty: got %h want 80000000", d); end
        peek(c_stat, d);
        checks++;
        if (d !== 32'h0 || rx_nonempty !== 1'b0) begin
            errors++;
            $display("FAIL stat_after_drain: got %h nonempty=%b want 00000000 0", d, rx_nonempty);
        end
    endtask

    task automatic test_overflow_and_full_pushpop();
        logic [31:0] d;
        logic [7:0]  exp_b;
        for (int i = 0; i < 9; i++) push(8'h10 + 8'(i));
        peek(c_stat, d);
        checks++;
        if (d !== 32'h8000_0008) begin errors++; $display("FAIL stat_overflow: got %h want 80000008", d); end
        store(c_stat, 32'h8000_0000, 4'hF);
        peek(c_stat, d);
        checks++;
        if (d !== 32'h0000_0008) begin errors++; $display("FAIL stat_ovf_clear: got %h want 00000008", d); end
        // full: push 0x55 and pop in the same cycle
        @(negedge clk);
        bus.A = c_rxdat; bus.MemRead = 1'b1; uart_valid = 1'b1; uart_byte = 8'h55;
        #1 d = bus.ReadData;
        @(posedge clk); #1;
        idle();
        checks++;
        if (d !== 32'h0000_0010) begin errors++; $display("FAIL full_pushpop_read: got %h want 00000010", d); end
        peek(c_stat, d);
        checks++;
        if (d !== 32'h0000_0008) begin errors++; $display("FAIL full_pushpop_stat: got %h want 00000008", d); end
        // drain: 0x11..0x17 then 0x55; 0x18 was lost to overflow
        for (int i = 0; i < 8; i++) begin
            exp_b = (i == 7) ? 8'h55 : (8'h11 + 8'(i));
            load_pop(c_rxdat, d);
            checks++;
            if (d !== {24'h0, exp_b}) begin
                errors++;
                $display("FAIL drain_%0d: got %h want %h", i, d, {24'h0, exp_b});
            end
        end
    endtask

    task automatic test_empty_pushpop();
        logic [31:0] d;
        @(negedge clk);
        bus.A = c_rxdat; bus.MemRead = 1'b1; uart_valid = 1'b1; uart_byte = 8'h77;
        #1 d = bus.ReadData;
        @(posedge clk); #1;
        idle();
        checks++;
        if (d !== 32'h8000_0000) begin errors++; $display("FAIL empty_pushpop_read: got %h want 80000000", d); end
        peek(c_stat, d);
        checks++;
        if (d !== 32'h0000_0001) begin errors++; $display("FAIL empty_pushpop_stat: got %h want 00000001", d); end
        load_pop(c_rxdat, d);
        checks++;
        if (d !== 32'h0000_0077) begin errors++; $display("FAIL empty_pushpop_byte: got %h want 00000077", d); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        load_pop(32'h0000_5000, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL unmapped_5000: got %h want FFFFFFFF", d); end
        load_pop(32'h0000_6000, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL unmapped_6000: got %h want FFFFFFFF", d); end
        checks++;
        if (bus_fault !== 1'b1 || fault_addr !== 32'h0000_5000) begin
            errors++;
            $display("FAIL fault_first_addr: got fault=%b addr=%h want 1 00005000", bus_fault, fault_addr);
        end
        store(c_fault, 32'h1234_5678, 4'hF);
        checks++;
        if (bus_fault !== 1'b0 || fault_addr !== 32'h0) begin
            errors++;
            $display("FAIL fault_store_clear: got fault=%b addr=%h want 0 00000000", bus_fault, fault_addr);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        push(8'hA1);
        push(8'hA2);
        checks++;
        if (rx_nonempty !== 1'b1) begin errors++; $display("FAIL pre_reset_nonempty: got %b want 1", rx_nonempty); end
        @(negedge clk);
        bus.A = 32'h1000; bus.WriteData = 32'h1234_5678; bus.ByteEn = 4'hF; bus.MemWrite = 1'b1;
        uart_valid = 1'b1; uart_byte = 8'hA3;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (rx_nonempty !== 1'b0) begin errors++; $display("FAIL async_reset_nonempty: got %b want 0", rx_nonempty); end
        @(posedge clk); #1;
        idle();
        @(negedge clk) rst = 1'b1;
        peek(c_stat, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL post_reset_stat: got %h want 00000000", d); end
        peek(32'h1000, d);
        checks++;
        if (d !== 32'hDEAD_55EF) begin errors++; $display("FAIL reset_store_discard: got %h want DEAD55EF", d); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.A = 32'h0;
        uart_byte = 8'h0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_data_region();
        test_stack();
        test_fifo_basic();
        test_overflow_and_full_pushpop();
        test_empty_pushpop();
        test_unmapped();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
